// File: rtl/lbist_sequencer.sv
// Logic BIST sequencer: drives seed loading, LFSR shifting, scan capture and
// MISR compaction for a fixed number of seeds and patterns, then compares the
// final signature against a golden value and reports go/no-go.
//
// Handshake: start_i is a level request sampled only in IDLE/DONE; abort_i is
// a synchronous override that wins over everything and returns to IDLE.
module lbist_sequencer #(
   parameter int                CHAIN_LEN    = 24,
   parameter int                PAT_PER_SEED = 200,
   parameter int                SEED_NUM     = 10,
   parameter int                MISR_W       = 16,
   parameter logic [MISR_W-1:0] MISR_GOLD    = '0,
   localparam int               SEED_W       = (SEED_NUM > 1) ? $clog2(SEED_NUM) : 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic [MISR_W-1:0] misr_sig_i,
   output logic [SEED_W-1:0] seed_idx_o,
   output logic              lfsr_load_o,
   output logic              lfsr_en_o,
   output logic              misr_clr_o,
   output logic              misr_en_o,
   output logic              test_en_o,
   output logic              test_mode_o,
   output logic              lbist_en_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              go_nogo_o,
   output logic [2:0]        state_o
);

   // Shift counter counts 0..CHAIN_LEN-1; pattern counter must hold PAT_PER_SEED.
   localparam int SHIFT_W = $clog2(CHAIN_LEN);
   localparam int PAT_W   = $clog2(PAT_PER_SEED + 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      INIT    = 3'd1,
      LOAD    = 3'd2,
      SHIFT   = 3'd3,
      CAPTURE = 3'd4,
      UNLOAD  = 3'd5,
      COMPARE = 3'd6,
      DONE    = 3'd7
   } state_t;

   state_t             state_q, state_d;
   logic [SHIFT_W-1:0] shift_q, shift_d;
   logic [PAT_W-1:0]   pat_q,   pat_d;
   logic [SEED_W-1:0]  seed_q,  seed_d;
   logic               first_q, first_d;  // first SHIFT after INIT: MISR held off
   logic               go_q,    go_d;

   // State and counter registers; reset clears everything asynchronously.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         shift_q <= '0;
         pat_q   <= '0;
         seed_q  <= '0;
         first_q <= 1'b0;
         go_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         pat_q   <= pat_d;
         seed_q  <= seed_d;
         first_q <= first_d;
         go_q    <= go_d;
      end
   end

   // Next-state and counter update; abort overrides every state.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      pat_d   = pat_q;
      seed_d  = seed_q;
      first_d = first_q;
      go_d    = go_q;
      if (abort_i) begin
         state_d = IDLE;
         shift_d = '0;
         pat_d   = '0;
         seed_d  = '0;
         first_d = 1'b0;
         go_d    = 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start_i) begin
                  state_d = INIT;
                  go_d    = 1'b0;
                  seed_d  = '0;
               end
            end
            INIT: begin
               seed_d  = '0;
               pat_d   = '0;
               shift_d = '0;
               first_d = 1'b1;
               state_d = LOAD;
            end
            LOAD: begin
               shift_d = '0;
               state_d = SHIFT;
            end
            SHIFT: begin
               if (shift_q == SHIFT_W'(CHAIN_LEN - 1)) begin
                  shift_d = '0;
                  first_d = 1'b0;
                  state_d = CAPTURE;
               end else begin
                  shift_d = shift_q + SHIFT_W'(1);
               end
            end
            CAPTURE: begin
               if (int'(pat_q) + 1 < PAT_PER_SEED) begin
                  pat_d   = pat_q + PAT_W'(1);
                  state_d = SHIFT;
               end else begin
                  pat_d = '0;
                  if (int'(seed_q) < SEED_NUM - 1) begin
                     seed_d  = seed_q + SEED_W'(1);
                     state_d = LOAD;
                  end else begin
                     state_d = UNLOAD;
                  end
               end
            end
            UNLOAD: begin
               if (shift_q == SHIFT_W'(CHAIN_LEN - 1)) begin
                  shift_d = '0;
                  state_d = COMPARE;
               end else begin
                  shift_d = shift_q + SHIFT_W'(1);
               end
            end
            COMPARE: begin
               go_d    = (misr_sig_i == MISR_GOLD);
               seed_d  = '0;
               state_d = DONE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Outputs decoded from state and counters only.
   always_comb begin
      busy_o      = (state_q != IDLE) && (state_q != DONE);
      test_mode_o = busy_o;
      lbist_en_o  = busy_o;
      misr_clr_o  = (state_q == INIT);
      lfsr_load_o = (state_q == LOAD);
      lfsr_en_o   = (state_q == SHIFT) || (state_q == UNLOAD);
      test_en_o   = lfsr_en_o;
      misr_en_o   = ((state_q == SHIFT) && !first_q) || (state_q == UNLOAD);
      done_o      = (state_q == DONE);
      go_nogo_o   = go_q;
      seed_idx_o  = seed_q;
      state_o     = state_q;
   end

endmodule

// File: doc/lbist_sequencer.md
LBIST_SEQUENCER -- requirements
Module: lbist_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk_i input 1 is the clock, and rst_ni input 1 is the asynchronous active-low reset.
REQ-002 CHAIN_LEN, default 24: scan chain length, i.e. shift cycles per pattern; legal values >= 2.
REQ-003 PAT_PER_SEED, default 200: patterns applied per seed; legal values >= 1.
REQ-004 SEED_NUM, default 10: number of seeds; legal values >= 1.
REQ-005 MISR_W, default 16: signature width.
REQ-006 MISR_GOLD, default 0: golden signature.
REQ-007 start_i  input  1  run request, level-sampled.
REQ-008 abort_i  input  1  synchronous abort.
REQ-009 misr_sig_i  input  MISR_W  current MISR signature.
REQ-010 seed_idx_o  output  max(1,clog2(SEED_NUM))  seed ROM index.
REQ-011 lfsr_load_o  output  1  load LFSR from seed ROM.
REQ-012 lfsr_en_o  output  1  advance LFSR.
REQ-013 misr_clr_o  output  1  clear MISR.
REQ-014 misr_en_o  output  1  compact MISR.
REQ-015 test_en_o  output  1  scan enable (1 = shift, 0 = capture).
REQ-016 test_mode_o  output  1  core in test mode.
REQ-017 lbist_en_o  output  1  LFSR drives scan-ins.
REQ-018 busy_o, done_o, go_nogo_o  output  1 each  status; go_nogo_o = 1 means pass.

Function
REQ-019 FSM states SHALL be IDLE, INIT, LOAD, SHIFT, CAPTURE, UNLOAD, COMPARE, DONE; all outputs SHALL be registered or decoded from state and counters only.
REQ-020 IDLE/DONE with start_i=1 and abort_i=0 -> INIT on the next edge; done_o and go_nogo_o SHALL clear on entering INIT.
REQ-021 INIT SHALL last 1 cycle: misr_clr_o=1, seed index=0, pattern count=0, then -> LOAD.
REQ-022 LOAD SHALL last 1 cycle: lfsr_load_o=1, seed_idx_o=current seed, then -> SHIFT.
REQ-023 SHIFT SHALL last exactly CHAIN_LEN cycles with test_en_o=1 and lfsr_en_o=1; misr_en_o=1 except during the first SHIFT after INIT, which unloads unknown functional state.
REQ-024 CAPTURE SHALL last 1 cycle with test_en_o=0, lfsr_en_o=0, misr_en_o=0, after which the pattern count increments.
REQ-025 After CAPTURE: if pattern count < PAT_PER_SEED -> SHIFT; else clear pattern count, and if seed < SEED_NUM-1 then increment seed and -> LOAD, else -> UNLOAD.
REQ-026 UNLOAD SHALL last CHAIN_LEN cycles with test_en_o=1, lfsr_en_o=1, misr_en_o=1, then -> COMPARE.
REQ-027 COMPARE SHALL last 1 cycle: go_nogo_o SHALL be registered as (misr_sig_i == MISR_GOLD), then -> DONE.
REQ-028 DONE: done_o=1, and go_nogo_o SHALL hold until the next start.
REQ-029 test_mode_o, lbist_en_o and busy_o SHALL be 1 in INIT through COMPARE and 0 in IDLE and DONE.
REQ-030 start_i SHALL be ignored while busy_o=1.
REQ-031 abort_i=1 in any busy state SHALL return the FSM to IDLE on the next edge: all outputs 0, counters cleared, done_o=0, go_nogo_o=0.
REQ-032 abort_i together with start_i in IDLE/DONE: abort SHALL win, going to or staying in IDLE, with done_o and go_nogo_o cleared.
REQ-033 Run length from INIT to COMPARE inclusive SHALL be 1 + SEED_NUM*(1 + PAT_PER_SEED*(CHAIN_LEN+1)) + CHAIN_LEN + 1 cycles.
REQ-034 Counters SHALL be sized from the parameters and SHALL never wrap within a run.

Reset
REQ-035 On rst_ni=0 the block SHALL asynchronously enter IDLE with all outputs 0 and all counters 0, including when reset occurs mid-run.
REQ-036 After reset deassertion, the first transition SHALL occur no earlier than the first clk_i rising edge with rst_ni=1.

Verification (CHAIN_LEN=4, PAT_PER_SEED=2, SEED_NUM=2, MISR_GOLD=16'hA5A5)
REQ-037 Pass run: start_i pulse, misr_sig_i=16'hA5A5 at COMPARE -> busy_o for 28 cycles, lfsr_load_o pulses at run cycles 2 and 13, seed_idx_o=0 then 1, done_o=1 and go_nogo_o=1 from cycle 29.
REQ-038 Fail run: same stimulus with misr_sig_i=16'h0001 -> done_o=1, go_nogo_o=0.
REQ-039 Cycle check: misr_en_o=0 in cycles 3-6, then =1 in every later SHIFT/UNLOAD cycle; test_en_o=0 exactly in cycles 7, 12, 18 and 23.
REQ-040 abort_i=1 at run cycle 10 -> IDLE next cycle, all outputs 0; a following start_i yields a full 28-cycle run.
REQ-041 rst_ni=0 asserted mid-SHIFT between edges -> outputs 0 immediately; start_i held high during a run -> no restart; start_i in DONE -> done_o and go_nogo_o clear, new run begins.
